// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Drain side of a single-clock block-RAM ring buffer. It drives the read port of the RAM
//   and follows the writer's pointer. It absorbs the one-cycle RAM read latency and delivers
//   words on a valid/ready stream through a two-entry (head + skid) buffer, so it can sustain
//   one word per cycle. It also returns its consumed-word pointer to the writer, which uses it
//   for full detection.
//
// Ports
//   clk_i        sole clock (RAM read clock and writer share it)
//   rst_i        synchronous reset, active-high; overrides everything
//   wptr_i       writer pointer incl. wrap bit (AW+1)
//   rptr_o       words captured from RAM into the buffer (AW+1), fed back to writer
//   level_o      wptr_i - rptr_o, mod 2**(AW+1)
//   raddr_o      RAM read address
//   re_o         RAM read enable
//   rclke_o      RAM read clock enable, tied high
//   rdata_i      RAM read data, valid the cycle after a re_o edge
//   flush_i      drop all pending data and jump to wptr_i
//   out_data_o   stream data (buffer head)
//   out_valid_o  stream valid
//   out_ready_i  stream ready
module ram_stream_reader #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW:0]   wptr_i,
    output logic [AW:0]   rptr_o,
    output logic [AW:0]   level_o,
    output logic [AW-1:0] raddr_o,
    output logic          re_o,
    output logic          rclke_o,
    input  logic [DW-1:0] rdata_i,
    input  logic          flush_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i
);

    logic [AW:0]   iptr_q, iptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          infl_q, infl_d;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] skid_q, skid_d;

    logic          pop;
    logic [2:0]    fill;        // buffer occupancy after this edge, before any new issue
    logic [1:0]    occ_after_pop;

    always_comb begin
        pop           = out_valid_o & out_ready_i;
        // pop implies occ_q >= 1, so this never underflows
        fill          = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        occ_after_pop = occ_q - {1'b0, pop};

        re_o = ~rst_i & ~flush_i & (iptr_q != wptr_i) & (fill < 3'd2);

        iptr_d = iptr_q;
        rptr_d = rptr_q;
        infl_d = 1'b0;
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;

        if (flush_i) begin
            // In-flight RDATA and buffered words are simply forgotten; head keeps its value.
            iptr_d = wptr_i;
            rptr_d = wptr_i;
            occ_d  = 2'd0;
        end else begin
            iptr_d = iptr_q + {{AW{1'b0}}, re_o};
            infl_d = re_o;
            rptr_d = rptr_q + {{AW{1'b0}}, infl_q};
            occ_d  = fill[1:0];

            if (pop && (occ_q == 2'd2)) begin
                head_d = skid_q;
            end
            if (infl_q) begin
                if (occ_after_pop == 2'd0) begin
                    head_d = rdata_i;
                end else begin
                    skid_d = rdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iptr_q <= '0;
            rptr_q <= '0;
            infl_q <= 1'b0;
            occ_q  <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            iptr_q <= iptr_d;
            rptr_q <= rptr_d;
            infl_q <= infl_d;
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign raddr_o     = iptr_q[AW-1:0];
    assign rclke_o     = 1'b1;
    assign rptr_o      = rptr_q;
    assign level_o     = wptr_i - rptr_q;
    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = head_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural one-cycle-latency RAM read port.
module tb_ram_stream_reader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   level;
    logic [AW-1:0] raddr;
    logic          re;
    logic          rclke;
    logic [DW-1:0] rdata;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total;
    int bad;

    ram_stream_reader #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wptr_i     (wptr),
        .rptr_o     (rptr),
        .level_o    (level),
        .raddr_o    (raddr),
        .re_o       (re),
        .rclke_o    (rclke),
        .rdata_i    (rdata),
        .flush_i    (flush),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port: data only meaningful the cycle after a read, garbage otherwise
    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        else    rdata <= 32'hDEAD_BEEF;
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        wptr      = '0;
        out_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        wptr      = 9'd3;
        #1;
        total++;
        if (re !== 1'b0) begin bad++; $display("FAIL reset_re_in_rst: got %0b want 0", re); end
        next_cycle();
        next_cycle();
        total++;
        if (out_data !== 32'h0) begin
            bad++; $display("FAIL reset_out_data: got %0h want 0", out_data);
        end
        wptr = '0;
        rst  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++;
            if (re !== 1'b0 || out_valid !== 1'b0 || rptr !== 9'd0 || level !== 9'd0
                || rclke !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold c=%0d: got re=%0b v=%0b rptr=%0d lvl=%0d ce=%0b want 0 0 0 0 1",
                         c, re, out_valid, rptr, level, rclke);
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        do_reset();
        mem[0]    = 32'hA5A5_0001;
        out_ready = 1'b1;
        wptr      = 9'd1;
        #1;
        total++;
        if (re !== 1'b1 || raddr !== 8'd0) begin
            bad++; $display("FAIL single_issue: got re=%0b raddr=%0d want 1 0", re, raddr);
        end
        next_cycle();
        total++;
        if (out_valid !== 1'b0 || rptr !== 9'd0 || re !== 1'b0) begin
            bad++; $display("FAIL single_e1: got v=%0b rptr=%0d re=%0b want 0 0 0",
                            out_valid, rptr, re);
        end
        next_cycle();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || rptr !== 9'd1 || level !== 9'd0) begin
            bad++; $display("FAIL single_e2: got v=%0b d=%0h rptr=%0d lvl=%0d want 1 a5a50001 1 0",
                            out_valid, out_data, rptr, level);
        end
        next_cycle();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'hA5A5_0001) begin
            bad++; $display("FAIL single_after_pop: got v=%0b d=%0h want 0 a5a50001",
                            out_valid, out_data);
        end
    endtask

    task automatic test_burst();
        logic exp_v;
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'hB000_0000 + i;
        out_ready = 1'b1;
        wptr      = 9'd8;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            exp_v = (c >= 2) && (c <= 9);
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL burst_valid c=%0d: got %0b want %0b", c, out_valid, exp_v);
            end else if (exp_v) begin
                total++;
                if (out_data !== 32'hB000_0000 + (c - 2)) begin
                    bad++; $display("FAIL burst_data c=%0d: got %0h want %0h",
                                    c, out_data, 32'hB000_0000 + (c - 2));
                end
            end
        end
        total++;
        if (rptr !== 9'd8 || level !== 9'd0) begin
            bad++; $display("FAIL burst_end: got rptr=%0d lvl=%0d want 8 0", rptr, level);
        end
    endtask

    task automatic test_backpressure();
        int nre;
        int got;
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'hC000_0000 + i;
        out_ready = 1'b0;
        wptr      = 9'd8;
        nre       = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (re) nre++;
            next_cycle();
        end
        total++;
        if (nre != 2) begin bad++; $display("FAIL bp_reads: got %0d want 2", nre); end
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 || rptr !== 9'd2 || level !== 9'd6) begin
            bad++; $display("FAIL bp_stall: got v=%0b d=%0h rptr=%0d lvl=%0d want 1 c0000000 2 6",
                            out_valid, out_data, rptr, level);
        end
        got = 0;
        for (int c = 0; c < 300 && got < 8; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== 32'hC000_0000 + got) begin
                    bad++; $display("FAIL bp_order n=%0d: got %0h want %0h",
                                    got, out_data, 32'hC000_0000 + got);
                end
                got++;
            end
            next_cycle();
        end
        total++;
        if (got != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", got); end
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        total++;
        if (out_valid !== 1'b0 || rptr !== 9'd8 || level !== 9'd0) begin
            bad++; $display("FAIL bp_end: got v=%0b rptr=%0d lvl=%0d want 0 8 0",
                            out_valid, rptr, level);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [0:3];
        int            n;
        int            w;
        exp_addr[0] = 8'd254;
        exp_addr[1] = 8'd255;
        exp_addr[2] = 8'd0;
        exp_addr[3] = 8'd1;
        do_reset();
        out_ready = 1'b1;
        wptr      = 9'd510;
        flush     = 1'b1;
        #1;
        total++;
        if (re !== 1'b0) begin bad++; $display("FAIL wrap_flush_re: got %0b want 0", re); end
        next_cycle();
        flush = 1'b0;
        total++;
        if (rptr !== 9'd510 || level !== 9'd0) begin
            bad++; $display("FAIL wrap_start: got rptr=%0d lvl=%0d want 510 0", rptr, level);
        end
        for (int i = 0; i < 4; i++) mem[exp_addr[i]] = 32'hD000_0000 + i;
        wptr = 9'd2;
        n    = 0;
        w    = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (re) begin
                if (n < 4) begin
                    total++;
                    if (raddr !== exp_addr[n]) begin
                        bad++; $display("FAIL wrap_raddr n=%0d: got %0d want %0d",
                                        n, raddr, exp_addr[n]);
                    end
                end
                n++;
            end
            if (out_valid) begin
                total++;
                if (out_data !== 32'hD000_0000 + w) begin
                    bad++; $display("FAIL wrap_data n=%0d: got %0h want %0h",
                                    w, out_data, 32'hD000_0000 + w);
                end
                w++;
            end
            next_cycle();
        end
        total++;
        if (n != 4 || w != 4 || rptr !== 9'd2 || level !== 9'd0) begin
            bad++; $display("FAIL wrap_end: got reads=%0d words=%0d rptr=%0d lvl=%0d want 4 4 2 0",
                            n, w, rptr, level);
        end
    endtask

    task automatic test_flush();
        int  stale;
        int  seen;
        do_reset();
        for (int i = 0; i < 21; i++) mem[i] = 32'hE000_0000 + i;
        out_ready = 1'b0;
        wptr      = 9'd20;
        next_cycle();
        next_cycle();
        // one word buffered, one read in flight
        total++;
        if (out_valid !== 1'b1 || rptr !== 9'd1) begin
            bad++; $display("FAIL flush_pre: got v=%0b rptr=%0d want 1 1", out_valid, rptr);
        end
        flush = 1'b1;
        #1;
        total++;
        if (re !== 1'b0) begin bad++; $display("FAIL flush_re: got %0b want 0", re); end
        next_cycle();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || rptr !== 9'd20 || level !== 9'd0) begin
            bad++; $display("FAIL flush_after: got v=%0b rptr=%0d lvl=%0d want 0 20 0",
                            out_valid, rptr, level);
        end
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid || re) stale++;
            next_cycle();
        end
        total++;
        if (stale != 0) begin bad++; $display("FAIL flush_stale: got %0d want 0", stale); end
        mem[20] = 32'hE0FF_0020;
        wptr    = 9'd21;
        seen    = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                total++;
                if (seen == 0 && out_data !== 32'hE0FF_0020) begin
                    bad++; $display("FAIL flush_next_word: got %0h want e0ff0020", out_data);
                end
                seen++;
            end
            next_cycle();
        end
        total++;
        if (seen != 1 || rptr !== 9'd21) begin
            bad++; $display("FAIL flush_next_count: got words=%0d rptr=%0d want 1 21", seen, rptr);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        wptr      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
